isp_tpg: RTL and testbench
==========================

# isp_tpg

Test pattern generator for the ISP lite pipeline. It produces a raster video stream (`out_href`, `out_vsync`, `out_data`) with the same timing conventions the ISP stages consume. The stream feeds the head of the pipeline, such as the noise-reduce and CFA stages, for bring-up and regression without a sensor. Frame geometry and blanking are set by parameters; the pattern is selected at runtime.

## Interface
- `BITS`, 8: pixel width.
- `WIDTH`, 1280: active pixels per line.
- `HEIGHT`, 960: active lines per frame.
- `HBLANK`, 160: blanking clocks after each line's active region; must be ≥1.
- `VSYNC_LINES`, 2: lines with `out_vsync`=1.
- `VBP_LINES`, 2: back-porch lines after vsync.
- `VFP_LINES`, 2: front-porch lines after the active lines.
- `pclk`, in, 1: pixel clock. Single clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: run request; sampled at frame boundaries only.
- `pattern_sel`, in, 2: 0 = moving ramp, 1 = gray bars, 2 = checkerboard, 3 = solid.
- `solid_value`, in, BITS: pixel value for pattern 3.
- `out_href`, out, 1: active-pixel qualifier.
- `out_vsync`, out, 1: frame sync, active high.
- `out_data`, out, BITS: pixel; forced to 0 whenever `out_href`=0.
- `frame_cnt`, out, 8: completed-frame count; wraps 255→0.
- `frame_done`, out, 1: one-cycle pulse on the last clock of each frame.

## Operation
- Every line is `WIDTH+HBLANK` clocks, in every state except IDLE. `h_cnt` runs 0..WIDTH+HBLANK-1. `v_cnt` counts lines within the current state.
- FSM sequence: IDLE → VSYNC (`VSYNC_LINES`) → VBP (`VBP_LINES`) → ACTIVE (`HEIGHT`) → VFP (`VFP_LINES`) → VSYNC or IDLE.
  - `out_vsync`=1 for the whole of VSYNC.
  - `out_href`=1 only in ACTIVE, for `h_cnt` < `WIDTH`.
- `enable` is sampled in IDLE and on the last clock of VFP.
  - 1: the next state is VSYNC.
  - 0: the next state is IDLE.
  - Deasserting `enable` mid-frame never truncates the frame.
- `pattern_sel` and `solid_value` are latched into shadow registers when VSYNC is entered. They are constant for the whole frame.
- Pixel coordinates: x = `h_cnt`, y = active line index (0..HEIGHT-1).
  - 0, moving ramp: (x + `frame_cnt`) mod 2^BITS.
  - 1, gray bars: bar = x / (WIDTH/8), clamped to 7. Level = LUT[bar], where LUT[k] = k·(2^BITS−1)/7 rounded down and computed at elaboration. For BITS=8: 0, 36, 72, 109, 145, 182, 218, 255.
  - 2, checkerboard: (x[3] ^ y[3]) ? 2^BITS−1 : 0.
  - 3, solid: latched `solid_value`.
- On the last clock of VFP:
  - `frame_done`=1.
  - `frame_cnt` increments; the new value is visible on the next clock.
- Frames abandoned by reset are not counted.

## Timing
- All outputs are registered.
- Reset values: `out_href`=0, `out_vsync`=0, `out_data`=0, `frame_cnt`=0, `frame_done`=0. FSM = IDLE; `h_cnt`=`v_cnt`=0.
- Start latency: `enable`=1 sampled in IDLE at edge k gives `out_vsync`=1 from the cycle after edge k. That cycle is `h_cnt`=0 of VSYNC line 0.
- In each active line, `out_href` rises on the clock where `h_cnt`=0. `out_data` is valid in that same cycle; there is no data/href skew.
- Frame period = (VSYNC_LINES + VBP_LINES + HEIGHT + VFP_LINES)·(WIDTH + HBLANK) clocks, with back-to-back frames and no gap.
- Reset mid-frame: outputs drop to reset values immediately (asynchronous). The block restarts from IDLE after `rst` is released.
- If `enable` is held at 1 during reset, the first vsync appears one clock after reset release.

## Structure
- Shared package/header `isp_tpg_pkg`:
  - pattern codes (`TPG_RAMP`, `TPG_BARS`, `TPG_CHECKER`, `TPG_SOLID`)
  - FSM state encoding
  - the bar-level LUT function
- One natural sub-module, `isp_vtc`: the timing FSM plus `h_cnt`/`v_cnt`. It exports `active`, `vsync`, x, y, and `frame_end`.
- The `isp_tpg` top adds the shadow registers, the pattern mux and the output registers.

## Test plan
Test parameters for all scenarios: WIDTH=16, HEIGHT=4, HBLANK=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1 (line = 20 clk, frame = 140 clk).
1. Reset, then `enable`=1, `pattern_sel`=3, `solid_value`=0x5A → `out_vsync` high for 20 clk; after 20 clk of VBP, 4 bursts of 16 href clk with `out_data`=0x5A; `out_data`=0 in blanking.
2. Run for 3 frames → `frame_done` pulses at clk 139, 279, 419 after the first vsync; `frame_cnt` reaches 3; the period is exactly 140.
3. Pattern 0 in frame 2 (`frame_cnt`=2) → line pixels 2..17. Pattern 1 → pixels 0,0,36,36,…,255,255. Pattern 2 at y=0 → 0 for x<8, 255 for x≥8.
4. Toggle `pattern_sel` and deassert `enable` mid-ACTIVE → the current frame is completed unchanged; the FSM goes to IDLE after VFP; no further vsync.
5. Assert `rst` mid-ACTIVE → all outputs 0 within the same cycle; after release with `enable`=1, vsync begins one clock later and `frame_cnt`=0.
6. Hold `frame_cnt` at 255 for a frame → it wraps to 0 after that frame ends.

Source files
------------

// File: rtl/isp_tpg_pkg.sv
// Shared definitions for the test pattern generator: pattern codes,
// timing FSM states and the gray-bar level function.
package isp_tpg_pkg;

  typedef enum logic [1:0] {
    TPG_RAMP    = 2'd0,
    TPG_BARS    = 2'd1,
    TPG_CHECKER = 2'd2,
    TPG_SOLID   = 2'd3
  } tpg_pattern_e;

  typedef enum logic [2:0] {
    VTC_IDLE   = 3'd0,
    VTC_VSYNC  = 3'd1,
    VTC_VBP    = 3'd2,
    VTC_ACTIVE = 3'd3,
    VTC_VFP    = 3'd4
  } vtc_state_e;

  // Level of gray bar k (0..7): k * full_scale / 7, rounded down.
  // Only evaluated on constants, so it folds away at elaboration.
  function automatic int unsigned bar_level(input int unsigned k, input int unsigned bits);
    return (k * ((32'd1 << bits) - 32'd1)) / 32'd7;
  endfunction

endpackage

// File: rtl/isp_tpg_if.sv
// Raster video stream as consumed by the ISP stages.
interface isp_tpg_if #(
  parameter int BITS = 8
);
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_data;

  modport master (output out_href, output out_vsync, output out_data);
  modport slave  (input  out_href, input  out_vsync, input  out_data);
endinterface

// File: rtl/isp_vtc.sv
// Video timing controller: frame FSM with horizontal/vertical counters.
//
// state      | meaning
// -----------+------------------------------------------------------
// VTC_IDLE   | stopped, counters held at 0, waiting for enable
// VTC_VSYNC  | VSYNC_LINES lines with vsync asserted
// VTC_VBP    | VBP_LINES back-porch lines
// VTC_ACTIVE | HEIGHT lines, first WIDTH clocks of each are pixels
// VTC_VFP    | VFP_LINES front-porch lines; last clock ends the frame
//
// The exported active/vsync/x/y/frame_end describe the cycle that follows
// the next clock edge, so the top can register them and still have its
// outputs line up with the FSM state without an extra cycle of delay.
module isp_vtc
  import isp_tpg_pkg::*;
#(
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int HBLANK      = 160,
  parameter int VSYNC_LINES = 2,
  parameter int VBP_LINES   = 2,
  parameter int VFP_LINES   = 2,
  parameter int HW          = $clog2(WIDTH + HBLANK),
  parameter int VW          = $clog2(HEIGHT + VSYNC_LINES + VBP_LINES + VFP_LINES)
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          enable,
  output logic          active,
  output logic          vsync,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          frame_end
);

  localparam int LINE_LEN = WIDTH + HBLANK;

  vtc_state_e    state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [VW-1:0] v_last_idx;
  logic          line_end;

  // State and counter registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= VTC_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  assign line_end = (h_cnt == HW'(LINE_LEN - 1));

  // Index of the last line in the current state.
  always_comb begin
    v_last_idx = '0;
    case (state)
      VTC_VSYNC:  v_last_idx = VW'(VSYNC_LINES - 1);
      VTC_VBP:    v_last_idx = VW'(VBP_LINES - 1);
      VTC_ACTIVE: v_last_idx = VW'(HEIGHT - 1);
      VTC_VFP:    v_last_idx = VW'(VFP_LINES - 1);
      default:    v_last_idx = '0;
    endcase
  end

  // Next-state and counter advance; enable only matters in IDLE and at frame end.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt + 1'b1;
    v_nxt     = v_cnt;
    if (state == VTC_IDLE) begin
      h_nxt = '0;
      v_nxt = '0;
      if (enable) state_nxt = VTC_VSYNC;
    end else if (line_end) begin
      h_nxt = '0;
      if (v_cnt == v_last_idx) begin
        v_nxt = '0;
        case (state)
          VTC_VSYNC:  state_nxt = VTC_VBP;
          VTC_VBP:    state_nxt = VTC_ACTIVE;
          VTC_ACTIVE: state_nxt = VTC_VFP;
          VTC_VFP:    state_nxt = enable ? VTC_VSYNC : VTC_IDLE;
          default:    state_nxt = VTC_IDLE;
        endcase
      end else begin
        v_nxt = v_cnt + 1'b1;
      end
    end
  end

  assign vsync     = (state_nxt == VTC_VSYNC);
  assign active    = (state_nxt == VTC_ACTIVE) && (h_nxt < HW'(WIDTH));
  assign x         = h_nxt;
  assign y         = v_nxt;
  assign frame_end = (state_nxt == VTC_VFP) && (h_nxt == HW'(LINE_LEN - 1)) &&
                     (v_nxt == VW'(VFP_LINES - 1));

endmodule

// File: rtl/isp_tpg.sv
// Test pattern generator: timing from isp_vtc, per-frame shadow of the
// pattern controls, pattern mux and registered stream outputs.
module isp_tpg
  import isp_tpg_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int HBLANK      = 160,
  parameter int VSYNC_LINES = 2,
  parameter int VBP_LINES   = 2,
  parameter int VFP_LINES   = 2
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      pattern_sel,
  input  logic [BITS-1:0] solid_value,
  isp_tpg_if.master       vid,
  output logic [7:0]      frame_cnt,
  output logic            frame_done
);

  localparam int HW = $clog2(WIDTH + HBLANK);
  localparam int VW = $clog2(HEIGHT + VSYNC_LINES + VBP_LINES + VFP_LINES);
  localparam int unsigned BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

  logic          active, vsync, frame_end;
  logic [HW-1:0] x;
  logic [VW-1:0] y;

  tpg_pattern_e    sel_q;
  logic [BITS-1:0] solid_q;
  logic [BITS-1:0] bar_lut [8];
  logic [BITS-1:0] pix;
  int unsigned     bar_raw;
  logic [2:0]      bar_idx;

  logic            href_q, vsync_q;
  logic [BITS-1:0] data_q;

  isp_vtc #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .HBLANK     (HBLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .VBP_LINES  (VBP_LINES),
    .VFP_LINES  (VFP_LINES),
    .HW         (HW),
    .VW         (VW)
  ) u_vtc (
    .pclk     (pclk),
    .rst      (rst),
    .enable   (enable),
    .active   (active),
    .vsync    (vsync),
    .x        (x),
    .y        (y),
    .frame_end(frame_end)
  );

  for (genvar k = 0; k < 8; k++) begin : g_lut
    assign bar_lut[k] = BITS'(bar_level(unsigned'(k), unsigned'(BITS)));
  end

  // Pattern controls are captured on entry to VSYNC and held for the frame.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sel_q   <= TPG_RAMP;
      solid_q <= '0;
    end else if (vsync && !vsync_q) begin
      sel_q   <= tpg_pattern_e'(pattern_sel);
      solid_q <= solid_value;
    end
  end

  // Bar index with the trailing partial bar folded into bar 7.
  always_comb begin
    bar_raw = 32'(x) / BAR_W;
    bar_idx = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
  end

  // Pixel value for the upcoming cycle.
  always_comb begin
    pix = '0;
    case (sel_q)
      TPG_RAMP:    pix = BITS'(32'(x) + 32'(frame_cnt));
      TPG_BARS:    pix = bar_lut[bar_idx];
      TPG_CHECKER: pix = (((32'(x) ^ 32'(y)) & 32'd8) != 32'd0) ? '1 : '0;
      TPG_SOLID:   pix = solid_q;
      default:     pix = '0;
    endcase
  end

  // Output registers; frame_cnt steps after the frame_done cycle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      data_q     <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      href_q     <= active;
      vsync_q    <= vsync;
      data_q     <= active ? pix : '0;
      frame_done <= frame_end;
      if (frame_done) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign vid.out_href  = href_q;
  assign vid.out_vsync = vsync_q;
  assign vid.out_data  = data_q;

endmodule

// File: tb/tb_isp_tpg.sv
// Bench for isp_tpg with a small frame geometry (20-clock lines, 140-clock frames).
module tb_isp_tpg;

  localparam int BITS   = 8;
  localparam int WIDTH  = 16;
  localparam int HEIGHT = 4;
  localparam int HBLANK = 4;
  localparam int VS     = 1;
  localparam int VBP    = 1;
  localparam int VFP    = 1;
  localparam int LINE   = WIDTH + HBLANK;
  localparam int FRAME  = LINE * (VS + VBP + HEIGHT + VFP);

  logic            pclk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic [1:0]      pattern_sel = 2'd0;
  logic [BITS-1:0] solid_value = '0;
  logic [7:0]      frame_cnt;
  logic            frame_done;

  isp_tpg_if #(.BITS(BITS)) vid ();

  isp_tpg #(
    .BITS       (BITS),
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .HBLANK     (HBLANK),
    .VSYNC_LINES(VS),
    .VBP_LINES  (VBP),
    .VFP_LINES  (VFP)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .solid_value(solid_value),
    .vid        (vid),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] d;
    logic       fd;
    logic [7:0] fc;
  } obs_t;

  int total = 0;
  int bad = 0;
  int bar_tab [8] = '{0, 36, 72, 109, 145, 182, 218, 255};
  int fc_model = 0;
  int cur_pat = 0;
  int cur_sv = 0;

  // Expected stream for position p (clocks since the frame's first vsync clock).
  function automatic obs_t model(int p, int fc, int pat, int sv);
    obs_t e;
    int line, x, y, bar;
    e = '0;
    line = p / LINE;
    x = p % LINE;
    e.vs = (line < VS);
    e.fd = (p == FRAME - 1);
    e.fc = 8'(fc % 256);
    if (line >= VS + VBP && line < VS + VBP + HEIGHT && x < WIDTH) begin
      y = line - VS - VBP;
      e.hr = 1'b1;
      bar = x / (WIDTH / 8);
      if (bar > 7) bar = 7;
      case (pat)
        0:       e.d = 8'((x + fc) % 256);
        1:       e.d = 8'(bar_tab[bar]);
        2:       e.d = ((((x / 8) + (y / 8)) % 2) == 1) ? 8'hFF : 8'h00;
        default: e.d = 8'(sv);
      endcase
    end
    return e;
  endfunction

  function automatic obs_t observe();
    return {vid.out_vsync, vid.out_href, vid.out_data, frame_done, frame_cnt};
  endfunction

  task automatic test_reset();
    obs_t got;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge pclk);
    got = observe();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset_values got=%h want=%h", got, obs_t'(0));
    end
    rst = 1'b0;
    repeat (6) @(negedge pclk);
    got = observe();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL idle_quiet got=%h want=%h", got, obs_t'(0));
    end
  endtask

  task automatic test_solid_frame();
    obs_t got, want;
    int chg;
    pattern_sel = 2'd3;
    solid_value = 8'h5A;
    enable = 1'b1;
    @(negedge pclk);
    cur_pat = 3;
    cur_sv = 8'h5A;
    chg = $urandom_range(40, 119);
    for (int p = 0; p < FRAME; p++) begin
      got = observe();
      want = model(p, fc_model, cur_pat, cur_sv);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL solid_frame p=%0d got=%h want=%h", p, got, want);
      end
      if (p == chg) begin
        pattern_sel = 2'd1;
        solid_value = 8'($urandom);
      end
      @(negedge pclk);
    end
    fc_model++;
    cur_pat = 1;
    cur_sv = solid_value;
  endtask

  task automatic test_patterns();
    obs_t got, want;
    int pats [4] = '{1, 0, 2, 0};
    int chg;
    for (int f = 0; f < 3; f++) begin
      chg = $urandom_range(40, 119);
      for (int p = 0; p < FRAME; p++) begin
        got = observe();
        want = model(p, fc_model, cur_pat, cur_sv);
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL patterns f=%0d pat=%0d p=%0d got=%h want=%h", f, cur_pat, p, got, want);
        end
        if (p == chg) begin
          pattern_sel = 2'(pats[f + 1]);
          solid_value = 8'($urandom);
        end
        @(negedge pclk);
      end
      fc_model++;
      cur_pat = pats[f + 1];
      cur_sv = solid_value;
    end
  endtask

  task automatic test_stop();
    obs_t got, want;
    int chg;
    chg = $urandom_range(40, 119);
    for (int p = 0; p < FRAME; p++) begin
      got = observe();
      want = model(p, fc_model, cur_pat, cur_sv);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stop_frame p=%0d got=%h want=%h", p, got, want);
      end
      if (p == chg) begin
        pattern_sel = 2'd2;
        solid_value = 8'($urandom);
        enable = 1'b0;
      end
      @(negedge pclk);
    end
    fc_model++;
    want = '0;
    want.fc = 8'(fc_model);
    for (int c = 0; c < 3 * FRAME; c++) begin
      got = observe();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stop_idle c=%0d got=%h want=%h", c, got, want);
      end
      @(negedge pclk);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, want;
    int mid, chg;
    pattern_sel = 2'd3;
    solid_value = 8'($urandom);
    enable = 1'b1;
    @(negedge pclk);
    cur_pat = 3;
    cur_sv = solid_value;
    mid = $urandom_range(42, 115);
    for (int p = 0; p < mid; p++) begin
      got = observe();
      want = model(p, fc_model, cur_pat, cur_sv);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL pre_reset p=%0d got=%h want=%h", p, got, want);
      end
      @(negedge pclk);
    end
    #1 rst = 1'b1;
    #1 got = observe();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", got, obs_t'(0));
    end
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    fc_model = 0;
    @(negedge pclk);
    chg = $urandom_range(40, 119);
    for (int p = 0; p < FRAME; p++) begin
      got = observe();
      want = model(p, fc_model, cur_pat, cur_sv);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL post_reset p=%0d got=%h want=%h", p, got, want);
      end
      if (p == chg) begin
        pattern_sel = 2'($urandom_range(0, 3));
        solid_value = 8'($urandom);
      end
      @(negedge pclk);
    end
    fc_model++;
    cur_pat = int'(pattern_sel);
    cur_sv = solid_value;
  endtask

  task automatic test_wrap();
    obs_t got, want;
    int chg;
    for (int f = 0; f < 255; f++) begin
      chg = $urandom_range(40, 119);
      for (int p = 0; p < FRAME; p++) begin
        got = observe();
        want = model(p, fc_model, cur_pat, cur_sv);
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL wrap_run fc=%0d p=%0d got=%h want=%h", fc_model, p, got, want);
        end
        if (p == chg) begin
          pattern_sel = 2'($urandom_range(0, 3));
          solid_value = 8'($urandom);
        end
        @(negedge pclk);
      end
      fc_model = (fc_model + 1) % 256;
      cur_pat = int'(pattern_sel);
      cur_sv = solid_value;
    end
    got = observe();
    want = model(0, 0, cur_pat, cur_sv);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL wrap_to_zero got=%h want=%h", got, want);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_solid_frame();
    test_patterns();
    test_stop();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
